// File: rtl/reward_sequencer.sv
// Packet-field sequencer: selects one reward job at a time (HB/INV ripple, MR, own INV, CHT burst, Data/SOS),
// drives the outgoing packet fields through a valid/ready handshake and owns the MR/CHT timers and HB lock.
module reward_sequencer #(
  parameter int WORD_WIDTH   = 16,
  parameter int NT_DEPTH     = 32,
  parameter int NT_IDX_W     = $clog2(NT_DEPTH),
  parameter int MR_TIMEOUT   = 15,
  parameter int CHT_TIMEOUT  = 15,
  parameter int MAX_INV_HOPS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [2:0]            fPacketType,
  input  logic [WORD_WIDTH-1:0] fHopsFromCH,
  input  logic                  iAmDestination,
  input  logic                  iHaveData,
  input  logic                  low_E,
  input  logic                  role,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] myEnergy,
  input  logic [WORD_WIDTH-1:0] myQValue,
  input  logic [WORD_WIDTH-1:0] hopsFromSink,
  input  logic [WORD_WIDTH-1:0] chosenCH,
  input  logic [WORD_WIDTH-1:0] chosenHop,
  output logic [NT_IDX_W-1:0]   nt_index,
  input  logic [WORD_WIDTH-1:0] nt_nodeID,
  input  logic [WORD_WIDTH-1:0] nt_chosenCH,
  input  logic [WORD_WIDTH-1:0] neighborCount,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [2:0]            rPacketType,
  output logic [WORD_WIDTH-1:0] rSourceID,
  output logic [WORD_WIDTH-1:0] rDestinationID,
  output logic [WORD_WIDTH-1:0] rEnergyLeft,
  output logic [WORD_WIDTH-1:0] rQValue,
  output logic [WORD_WIDTH-1:0] rSourceHops,
  output logic [WORD_WIDTH-1:0] rChosenCH,
  output logic [WORD_WIDTH-1:0] rHopsFromCH,
  output logic [WORD_WIDTH-1:0] rTimeslot,
  output logic                  busy,
  output logic                  reward_done
);

  // state  | meaning
  // IDLE   | waiting; job priority evaluated every cycle
  // SELECT | job latched, packet fields built
  // FETCH  | neighbor table read issued (nt_index on bus)
  // CHECK  | table entry sampled, member -> SEND
  // SEND   | tx_valid held until tx_ready
  // DONE   | reward_done pulse
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_SEND   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [2:0] PT_HB   = 3'b000;
  localparam logic [2:0] PT_INV  = 3'b010;
  localparam logic [2:0] PT_MR   = 3'b011;
  localparam logic [2:0] PT_CHT  = 3'b100;
  localparam logic [2:0] PT_DATA = 3'b101;
  localparam logic [2:0] PT_SOS  = 3'b110;
  localparam logic [2:0] PT_NONE = 3'b111;

  localparam logic [2:0] J_HB   = 3'd0;
  localparam logic [2:0] J_INV  = 3'd1;
  localparam logic [2:0] J_MR   = 3'd2;
  localparam logic [2:0] J_CHT  = 3'd3;
  localparam logic [2:0] J_FWD  = 3'd4;
  localparam logic [2:0] J_OWN  = 3'd5;
  localparam logic [2:0] J_DATA = 3'd6;
  localparam logic [2:0] J_SOS  = 3'd7;

  logic [2:0]            state;
  logic [2:0]            job;
  logic [2:0]            sel_job;
  logic                  sel_valid;
  logic                  take_job;
  logic                  accept;
  logic                  fwd_sos;
  logic                  hb_lock;
  logic                  role_q;
  logic                  role_rise;
  logic                  inv_ok;
  logic                  mr_armed;
  logic                  cht_armed;
  logic                  mr_exp;
  logic                  cht_exp;
  logic                  idx_last;
  logic                  member;
  logic [WORD_WIDTH-1:0] mr_count;
  logic [WORD_WIDTH-1:0] cht_count;
  logic [WORD_WIDTH-1:0] inv_hops;
  logic [WORD_WIDTH-1:0] hops_from_ch;
  logic [WORD_WIDTH-1:0] data_dest;

  assign busy        = (state != S_IDLE);
  assign reward_done = (state == S_DONE);
  assign role_rise   = role & ~role_q;
  assign inv_ok      = en && (fPacketType == PT_INV) && (fHopsFromCH < WORD_WIDTH'(MAX_INV_HOPS));
  assign mr_exp      = mr_armed && (mr_count == '0);
  assign cht_exp     = cht_armed && (cht_count == '0);
  assign take_job    = (state == S_IDLE) && sel_valid;
  assign accept      = (state == S_SEND) && tx_valid && tx_ready;
  assign member      = (nt_chosenCH == myNodeID);
  assign data_dest   = (hopsFromSink == WORD_WIDTH'(1)) ? '0 : chosenHop;
  // Last entry either by count or by table size, so the index can never run off the table.
  assign idx_last    = (nt_index == NT_IDX_W'(NT_DEPTH - 1)) ||
                       ((WORD_WIDTH'(nt_index) + WORD_WIDTH'(1)) >= neighborCount);

  always_comb begin
    sel_valid = 1'b1;
    sel_job   = J_HB;
    if (cht_exp && role)                                                   sel_job = J_CHT;
    else if (mr_exp && !role)                                              sel_job = J_MR;
    else if (en && (fPacketType == PT_HB) && !hb_lock)                     sel_job = J_HB;
    else if (inv_ok)                                                       sel_job = J_INV;
    else if (en && ((fPacketType == PT_DATA) || (fPacketType == PT_SOS)) && iAmDestination)
                                                                           sel_job = J_FWD;
    else if (role_rise)                                                    sel_job = J_OWN;
    else if (iHaveData)                                                    sel_job = J_DATA;
    else if (low_E)                                                        sel_job = J_SOS;
    else                                                                   sel_valid = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mr_armed <= 1'b0;
      mr_count <= '0;
    end else if (role) begin
      mr_armed <= 1'b0;
      mr_count <= '0;
    end else if (take_job && (sel_job == J_MR)) begin
      mr_armed <= 1'b0;
    end else if (inv_ok && !mr_armed) begin
      mr_armed <= 1'b1;
      mr_count <= WORD_WIDTH'(MR_TIMEOUT);
    end else if (mr_count != '0) begin
      mr_count <= mr_count - WORD_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cht_armed <= 1'b0;
      cht_count <= '0;
    end else if (!role) begin
      cht_armed <= 1'b0;
      cht_count <= '0;
    end else if (take_job && (sel_job == J_CHT)) begin
      cht_armed <= 1'b0;
    end else if (accept && (job == J_OWN)) begin
      cht_armed <= 1'b1;
      cht_count <= WORD_WIDTH'(CHT_TIMEOUT);
    end else if (cht_count != '0) begin
      cht_count <= cht_count - WORD_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hb_lock <= 1'b0;
      role_q  <= 1'b0;
    end else begin
      role_q <= role;
      if (take_job && (sel_job == J_HB))
        hb_lock <= 1'b1;
      else if (en && (fPacketType == PT_DATA))
        hb_lock <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      job            <= J_HB;
      fwd_sos        <= 1'b0;
      inv_hops       <= '0;
      hops_from_ch   <= '0;
      nt_index       <= '0;
      tx_valid       <= 1'b0;
      rPacketType    <= PT_NONE;
      rSourceID      <= '0;
      rDestinationID <= '1;
      rEnergyLeft    <= '0;
      rQValue        <= '0;
      rSourceHops    <= '0;
      rChosenCH      <= '0;
      rHopsFromCH    <= '0;
      rTimeslot      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_valid) begin
            job      <= sel_job;
            inv_hops <= fHopsFromCH;
            fwd_sos  <= (fPacketType == PT_SOS);
            state    <= S_SELECT;
          end
        end
        S_SELECT: begin
          rSourceID      <= myNodeID;
          rEnergyLeft    <= myEnergy;
          rQValue        <= myQValue;
          rSourceHops    <= hopsFromSink;
          rChosenCH      <= chosenCH;
          rTimeslot      <= '0;
          rHopsFromCH    <= hops_from_ch;
          rDestinationID <= '1;
          tx_valid       <= 1'b1;
          state          <= S_SEND;
          case (job)
            J_HB:  rPacketType <= PT_HB;
            J_INV: begin
              rPacketType  <= PT_INV;
              rHopsFromCH  <= inv_hops + WORD_WIDTH'(1);
              hops_from_ch <= inv_hops + WORD_WIDTH'(1);
            end
            J_OWN: begin
              rPacketType  <= PT_INV;
              rHopsFromCH  <= '0;
              hops_from_ch <= '0;
            end
            J_MR: begin
              rPacketType    <= PT_MR;
              rDestinationID <= chosenCH;
            end
            J_CHT: begin
              rPacketType <= PT_CHT;
              nt_index    <= '0;
              tx_valid    <= 1'b0;
              state       <= (neighborCount == '0) ? S_DONE : S_FETCH;
            end
            J_FWD: begin
              rPacketType    <= fwd_sos ? PT_SOS : PT_DATA;
              rDestinationID <= data_dest;
            end
            J_DATA: begin
              rPacketType    <= PT_DATA;
              rDestinationID <= data_dest;
            end
            default: begin
              rPacketType    <= PT_SOS;
              rDestinationID <= data_dest;
            end
          endcase
        end
        S_FETCH: state <= S_CHECK;
        S_CHECK: begin
          if (member) begin
            rDestinationID <= nt_nodeID;
            rTimeslot      <= rTimeslot + WORD_WIDTH'(1);
            tx_valid       <= 1'b1;
            state          <= S_SEND;
          end else if (idx_last) begin
            state <= S_DONE;
          end else begin
            nt_index <= nt_index + NT_IDX_W'(1);
            state    <= S_FETCH;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if ((job == J_CHT) && !idx_last) begin
              nt_index <= nt_index + NT_IDX_W'(1);
              state    <= S_FETCH;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reward_sequencer.sv
// Directed bench for reward_sequencer: HB lock, INV ripple/MR timeout, own INV + CHT burst with stall,
// Data/SOS destinations, table saturation, empty table and reset mid-burst.
module tb_reward_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  fPacketType;
  logic [15:0] fHopsFromCH;
  logic        iAmDestination, iHaveData, low_E, role;
  logic [15:0] myNodeID, myEnergy, myQValue, hopsFromSink, chosenCH, chosenHop;
  logic [4:0]  nt_index;
  logic [15:0] nt_nodeID, nt_chosenCH, neighborCount;
  logic        tx_valid, tx_ready;
  logic [2:0]  rPacketType;
  logic [15:0] rSourceID, rDestinationID, rEnergyLeft, rQValue, rSourceHops, rChosenCH, rHopsFromCH, rTimeslot;
  logic        busy, reward_done;

  int checks = 0;
  int errors = 0;

  logic [15:0] tbl_id [0:31];
  logic [15:0] tbl_ch [0:31];
  logic [15:0] got_dest [0:3];
  logic [15:0] got_ts   [0:3];
  logic [2:0]  got_type [0:3];

  reward_sequencer dut (
    .clk(clk), .rst(rst), .en(en), .fPacketType(fPacketType), .fHopsFromCH(fHopsFromCH),
    .iAmDestination(iAmDestination), .iHaveData(iHaveData), .low_E(low_E), .role(role),
    .myNodeID(myNodeID), .myEnergy(myEnergy), .myQValue(myQValue), .hopsFromSink(hopsFromSink),
    .chosenCH(chosenCH), .chosenHop(chosenHop), .nt_index(nt_index), .nt_nodeID(nt_nodeID),
    .nt_chosenCH(nt_chosenCH), .neighborCount(neighborCount), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rPacketType(rPacketType), .rSourceID(rSourceID), .rDestinationID(rDestinationID),
    .rEnergyLeft(rEnergyLeft), .rQValue(rQValue), .rSourceHops(rSourceHops), .rChosenCH(rChosenCH),
    .rHopsFromCH(rHopsFromCH), .rTimeslot(rTimeslot), .busy(busy), .reward_done(reward_done)
  );

  always #5 clk = ~clk;

  // Neighbor table with one cycle of read latency.
  always @(posedge clk) begin
    nt_nodeID   <= tbl_id[nt_index];
    nt_chosenCH <= tbl_ch[nt_index];
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [2:0] t, input logic [15:0] hops);
    en = 1'b1; fPacketType = t; fHopsFromCH = hops;
    tick();
    en = 1'b0;
  endtask

  task automatic wait_tx(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (tx_valid) begin
        n = i;
        break;
      end
    end
  endtask

  // Drop and re-raise role, let the own INV go out and its done pulse pass.
  task automatic role_cycle(input string tag);
    int n;
    role = 1'b0; tick();
    role = 1'b1; tick();
    wait_tx(4, n);
    chk_eq({tag, "_own_inv_lat"}, n, 1);
    chk_eq({tag, "_own_inv_type"}, rPacketType, 3'b010);
    chk_eq({tag, "_own_inv_hops"}, rHopsFromCH, 16'h0000);
    tick(); tick();
  endtask

  task automatic run_burst(input bit do_stall, output int pkts, output int maxidx,
                           output bit done_seen, output bit stall_ok);
    logic [15:0] sd, sts;
    pkts = 0; maxidx = 0; done_seen = 1'b0; stall_ok = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (int'(nt_index) > maxidx) maxidx = int'(nt_index);
      if (reward_done) begin
        done_seen = 1'b1;
        break;
      end
      if (tx_valid) begin
        if (pkts < 4) begin
          got_dest[pkts] = rDestinationID; got_ts[pkts] = rTimeslot; got_type[pkts] = rPacketType;
        end
        pkts++;
        if (do_stall && pkts == 1) begin
          sd = rDestinationID; sts = rTimeslot; tx_ready = 1'b0;
          repeat (10) begin
            tick();
            if (!tx_valid || rDestinationID !== sd || rTimeslot !== sts || rPacketType !== 3'b100)
              stall_ok = 1'b0;
          end
          tx_ready = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int  n, pkts, maxidx;
    bit  done_seen, stall_ok, seen;

    rst = 1'b1; en = 1'b0; fPacketType = 3'b000; fHopsFromCH = '0;
    iAmDestination = 1'b0; iHaveData = 1'b0; low_E = 1'b0; role = 1'b0;
    myNodeID = 16'h0042; myEnergy = 16'h0300; myQValue = 16'h0011; hopsFromSink = 16'd3;
    chosenCH = 16'h0050; chosenHop = 16'h0007; neighborCount = 16'd0; tx_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tbl_id[i] = 16'h0100 + 16'(i);
      tbl_ch[i] = 16'h0099;
    end
    repeat (3) tick();

    chk_eq("rst_tx_valid", tx_valid, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", reward_done, 0);
    chk_eq("rst_type", rPacketType, 3'b111);
    chk_eq("rst_dest", rDestinationID, 16'hFFFF);
    chk_eq("rst_src", rSourceID, 0);
    chk_eq("rst_ts", rTimeslot, 0);
    chk_eq("rst_idx", nt_index, 0);
    chk_eq("rst_mr_armed", dut.mr_armed, 0);
    rst = 1'b0; tick();

    // T1: HB, locked HB, Data unlocks, HB again
    strobe(3'b000, 0);
    wait_tx(4, n);
    chk_eq("t1_hb_lat", n, 1);
    chk_eq("t1_hb_type", rPacketType, 3'b000);
    chk_eq("t1_hb_dest", rDestinationID, 16'hFFFF);
    chk_eq("t1_hb_src", rSourceID, 16'h0042);
    chk_eq("t1_hb_energy", rEnergyLeft, 16'h0300);
    chk_eq("t1_hb_q", rQValue, 16'h0011);
    chk_eq("t1_hb_shops", rSourceHops, 16'd3);
    chk_eq("t1_hb_ch", rChosenCH, 16'h0050);
    tick();
    chk_eq("t1_hb_done", reward_done, 1);
    tick();
    chk_eq("t1_idle", busy, 0);
    strobe(3'b000, 0);
    wait_tx(6, n);
    chk_eq("t1_hb_locked", n, -1);
    strobe(3'b101, 0);
    tick();
    strobe(3'b000, 0);
    wait_tx(4, n);
    chk_eq("t1_hb_unlocked", n, 1);
    chk_eq("t1_hb2_type", rPacketType, 3'b000);
    tick(); tick();

    // T2: INV ripple, out-of-range INV dropped, MR after timeout
    strobe(3'b010, 16'd3);
    wait_tx(4, n);
    chk_eq("t2_inv_lat", n, 1);
    chk_eq("t2_inv_type", rPacketType, 3'b010);
    chk_eq("t2_inv_hops", rHopsFromCH, 16'd4);
    chk_eq("t2_inv_dest", rDestinationID, 16'hFFFF);
    tick(); tick();
    strobe(3'b010, 16'd4);
    // Timer hits 0 fifteen edges after the INV strobe; SELECT and SEND add two more.
    wait_tx(20, n);
    chk_eq("t2_mr_time", 4 + n, 17);
    chk_eq("t2_mr_type", rPacketType, 3'b011);
    chk_eq("t2_mr_dest", rDestinationID, 16'h0050);
    tick(); tick();

    // T3/T4: own INV then CHT burst to members 1,3,4 with a 10-cycle stall on the first
    tbl_ch[1] = 16'h0042; tbl_ch[3] = 16'h0042; tbl_ch[4] = 16'h0042;
    neighborCount = 16'd5;
    role = 1'b1; tick();
    wait_tx(4, n);
    chk_eq("t3_own_inv_lat", n, 1);
    chk_eq("t3_own_inv_type", rPacketType, 3'b010);
    chk_eq("t3_own_inv_hops", rHopsFromCH, 0);
    chk_eq("t3_own_inv_dest", rDestinationID, 16'hFFFF);
    tick();
    chk_eq("t3_own_inv_done", reward_done, 1);
    tick();
    run_burst(1'b1, pkts, maxidx, done_seen, stall_ok);
    chk_eq("t3_cht_count", pkts, 3);
    chk_eq("t3_cht_type", got_type[0], 3'b100);
    chk_eq("t3_cht_dest0", got_dest[0], 16'h0101);
    chk_eq("t3_cht_ts0", got_ts[0], 1);
    chk_eq("t3_cht_dest1", got_dest[1], 16'h0103);
    chk_eq("t3_cht_ts1", got_ts[1], 2);
    chk_eq("t3_cht_dest2", got_dest[2], 16'h0104);
    chk_eq("t3_cht_ts2", got_ts[2], 3);
    chk_eq("t3_cht_done", done_seen, 1);
    chk_eq("t4_stall_stable", stall_ok, 1);
    tick();
    chk_eq("t3_idle", busy, 0);

    // Index saturation: count beyond table size, no members
    tbl_ch[1] = 16'h0099; tbl_ch[3] = 16'h0099; tbl_ch[4] = 16'h0099;
    neighborCount = 16'd40;
    role_cycle("sat");
    run_burst(1'b0, pkts, maxidx, done_seen, stall_ok);
    chk_eq("sat_pkts", pkts, 0);
    chk_eq("sat_maxidx", maxidx, 31);
    chk_eq("sat_done", done_seen, 1);

    // Empty table: straight to done
    neighborCount = 16'd0;
    role_cycle("empty");
    run_burst(1'b0, pkts, maxidx, done_seen, stall_ok);
    chk_eq("empty_pkts", pkts, 0);
    chk_eq("empty_done", done_seen, 1);
    tick(); tick();

    // T5: Data/SOS destinations
    role = 1'b0; tick();
    hopsFromSink = 16'd1; iAmDestination = 1'b1;
    strobe(3'b101, 0);
    wait_tx(4, n);
    chk_eq("t5_fwd_type", rPacketType, 3'b101);
    chk_eq("t5_fwd_dest_sink", rDestinationID, 16'h0000);
    tick(); tick();
    hopsFromSink = 16'd3;
    strobe(3'b101, 0);
    wait_tx(4, n);
    chk_eq("t5_fwd_dest_hop", rDestinationID, 16'h0007);
    tick(); tick();
    iAmDestination = 1'b0;
    low_E = 1'b1;
    wait_tx(4, n);
    chk_eq("t5_sos_lat", n, 2);
    chk_eq("t5_sos_type", rPacketType, 3'b110);
    chk_eq("t5_sos_dest", rDestinationID, 16'h0007);
    low_E = 1'b0;
    tick(); tick();
    iHaveData = 1'b1; low_E = 1'b1;
    wait_tx(4, n);
    chk_eq("t5_data_prio", rPacketType, 3'b101);
    iHaveData = 1'b0; low_E = 1'b0;
    tick(); tick();

    // T6: reset in the middle of a stalled burst
    tbl_ch[1] = 16'h0042; tbl_ch[3] = 16'h0042; tbl_ch[4] = 16'h0042;
    neighborCount = 16'd5;
    role_cycle("t6");
    tx_ready = 1'b0;
    wait_tx(100, n);
    chk_eq("t6_burst_started", rPacketType, 3'b100);
    rst = 1'b1; role = 1'b0;
    tick();
    chk_eq("t6_tx_valid", tx_valid, 0);
    chk_eq("t6_type", rPacketType, 3'b111);
    chk_eq("t6_dest", rDestinationID, 16'hFFFF);
    chk_eq("t6_busy", busy, 0);
    chk_eq("t6_ts", rTimeslot, 0);
    chk_eq("t6_idx", nt_index, 0);
    chk_eq("t6_mr_armed", dut.mr_armed, 0);
    chk_eq("t6_cht_armed", dut.cht_armed, 0);
    rst = 1'b0; tx_ready = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (reward_done || tx_valid) seen = 1'b1;
    end
    chk_eq("t6_no_done", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
